// File: rtl/ad_nios_counter_pkg.sv
// rtl/ad_nios_counter_pkg.sv - shared constants, one-shot state type and terminal-value helper
package ad_nios_counter_pkg;

   localparam int MODE_FREE_RUN = 0;
   localparam int MODE_ONE_SHOT = 1;

   typedef enum logic [1:0] {
      OS_IDLE = 2'd0,
      OS_RUN  = 2'd1,
      OS_HALT = 2'd2
   } os_state_t;

   // Highest count value: MODULUS-1, or all ones when the modulus is the natural 2**width.
   function automatic logic [31:0] terminal_value(input int width, input longint unsigned modulus);
      longint unsigned top;
      if (modulus == 64'd0)
         top = (64'd1 << width) - 64'd1;
      else
         top = modulus - 64'd1;
      return top[31:0];
   endfunction

endpackage

// File: rtl/ad_nios_counter_snap.sv
// rtl/ad_nios_counter_snap.sv - snapshot register with valid/ack handshake
import ad_nios_counter_pkg::*;

module ad_nios_counter_snap #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             ena,
   input  logic             capture,
   input  logic             snap_ack,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] snap_data,
   output logic             snap_valid
);

   // A capture always wins over an ack; ack clears valid even while ena is low.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         snap_data  <= '0;
         snap_valid <= 1'b0;
      end else if (ena && capture) begin
         snap_data  <= din;
         snap_valid <= 1'b1;
      end else if (snap_ack && snap_valid) begin
         snap_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ad_nios_param_counter.sv
// rtl/ad_nios_param_counter.sv - parametrised up/down modulus counter stage with one-shot and snapshot
import ad_nios_counter_pkg::*;

module ad_nios_param_counter #(
   parameter int          WIDTH       = 16,
   parameter longint      MODULUS     = 0,
   parameter logic [31:0] POWER_UP    = 32'd0,
   parameter int          MODE        = 0,
   parameter int          CIN_USED    = 0,
   parameter int          UPDOWN_USED = 1
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             ena,
   input  logic             cin,
   input  logic             sclr,
   input  logic             sload,
   input  logic [WIDTH-1:0] load_data,
   input  logic             up_dn,
   input  logic             capture,
   input  logic             snap_ack,
   output logic [WIDTH-1:0] regout,
   output logic             cout,
   output logic             tc,
   output logic             done,
   output logic [WIDTH-1:0] snap_data,
   output logic             snap_valid
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("ad_nios_param_counter: WIDTH must be 2..32");
   end
   if (MODULUS < 0 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
      $error("ad_nios_param_counter: MODULUS must be 0..2**WIDTH");
   end

   localparam logic [31:0]      TOP32    = terminal_value(WIDTH, MODULUS);
   localparam logic [WIDTH-1:0] TOP      = TOP32[WIDTH-1:0];
   localparam logic [WIDTH-1:0] PU       = POWER_UP[WIDTH-1:0];
   localparam bit               ONE_SHOT = (MODE == MODE_ONE_SHOT);

   os_state_t        state;
   logic             count_up;
   logic             cnt_en;
   logic             at_terminal;
   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] load_clamped;

   // Direction, enable qualification, terminal detect and the next stepped value.
   always_comb begin
      count_up     = (UPDOWN_USED != 0) ? up_dn : 1'b1;
      cnt_en       = ena & ((CIN_USED != 0) ? cin : 1'b1) & (state == OS_RUN);
      at_terminal  = count_up ? (regout == TOP) : (regout == '0);
      next_count   = regout;
      if (count_up)
         next_count = at_terminal ? '0 : regout + WIDTH'(1);
      else
         next_count = at_terminal ? TOP : regout - WIDTH'(1);
      load_clamped = (load_data > TOP) ? TOP : load_data;
   end

   assign cout = cnt_en & at_terminal;

   // Count register, terminal pulse and one-shot state; sclr > sload > count, all gated by ena.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         regout <= PU;
         tc     <= 1'b0;
         done   <= 1'b0;
         state  <= ONE_SHOT ? OS_IDLE : OS_RUN;
      end else begin
         tc <= 1'b0;
         if (ena) begin
            if (sclr) begin
               regout <= '0;
               if (ONE_SHOT) begin
                  state <= OS_RUN;
                  done  <= 1'b0;
               end
            end else if (sload) begin
               regout <= load_clamped;
               if (ONE_SHOT) begin
                  state <= OS_RUN;
                  done  <= 1'b0;
               end
            end else if (cnt_en) begin
               tc <= at_terminal;
               if (ONE_SHOT && at_terminal) begin
                  state <= OS_HALT;
                  done  <= 1'b1;
               end else begin
                  regout <= next_count;
               end
            end
         end
      end
   end

   ad_nios_counter_snap #(
      .WIDTH(WIDTH)
   ) u_snap (
      .clk        (clk),
      .aclr       (aclr),
      .ena        (ena),
      .capture    (capture),
      .snap_ack   (snap_ack),
      .din        (regout),
      .snap_data  (snap_data),
      .snap_valid (snap_valid)
   );

endmodule

// File: tb/tb_ad_nios_param_counter.sv
// tb/tb_ad_nios_param_counter.sv - directed self-checking bench for ad_nios_param_counter
module tb_ad_nios_param_counter;

   logic clk = 1'b0;
   logic aclr;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // dut a: 8-bit, modulus 10, power-up 5, free-run
   logic       a_ena, a_sclr, a_sload, a_updn, a_cap, a_ack;
   logic [7:0] a_ld, a_q, a_snap;
   logic       a_cout, a_tc, a_done, a_sv;

   // dut b: 4-bit one-shot
   logic       b_ena, b_sclr, b_sload, b_updn;
   logic [3:0] b_ld, b_q, b_snap;
   logic       b_cout, b_tc, b_done, b_sv;

   // cascade: low and high 4-bit stages
   logic       c_ena, c_sload;
   logic [3:0] l_ld, h_ld, l_q, h_q, l_snap, h_snap;
   logic       l_cout, l_tc, l_done, l_sv, h_cout, h_tc, h_done, h_sv;

   // dut d: 16-bit snapshot
   logic        d_ena, d_sload, d_cap, d_ack;
   logic [15:0] d_ld, d_q, d_snap;
   logic        d_cout, d_tc, d_done, d_sv;

   ad_nios_param_counter #(.WIDTH(8), .MODULUS(10), .POWER_UP(5), .MODE(0), .CIN_USED(0), .UPDOWN_USED(1)) u_a (
      .clk(clk), .aclr(aclr), .ena(a_ena), .cin(1'b0), .sclr(a_sclr), .sload(a_sload),
      .load_data(a_ld), .up_dn(a_updn), .capture(a_cap), .snap_ack(a_ack),
      .regout(a_q), .cout(a_cout), .tc(a_tc), .done(a_done), .snap_data(a_snap), .snap_valid(a_sv));

   ad_nios_param_counter #(.WIDTH(4), .MODULUS(0), .POWER_UP(0), .MODE(1), .CIN_USED(0), .UPDOWN_USED(1)) u_b (
      .clk(clk), .aclr(aclr), .ena(b_ena), .cin(1'b0), .sclr(b_sclr), .sload(b_sload),
      .load_data(b_ld), .up_dn(b_updn), .capture(1'b0), .snap_ack(1'b0),
      .regout(b_q), .cout(b_cout), .tc(b_tc), .done(b_done), .snap_data(b_snap), .snap_valid(b_sv));

   ad_nios_param_counter #(.WIDTH(4), .MODULUS(0), .POWER_UP(0), .MODE(0), .CIN_USED(0), .UPDOWN_USED(1)) u_lo (
      .clk(clk), .aclr(aclr), .ena(c_ena), .cin(1'b0), .sclr(1'b0), .sload(c_sload),
      .load_data(l_ld), .up_dn(1'b1), .capture(1'b0), .snap_ack(1'b0),
      .regout(l_q), .cout(l_cout), .tc(l_tc), .done(l_done), .snap_data(l_snap), .snap_valid(l_sv));

   ad_nios_param_counter #(.WIDTH(4), .MODULUS(0), .POWER_UP(0), .MODE(0), .CIN_USED(1), .UPDOWN_USED(1)) u_hi (
      .clk(clk), .aclr(aclr), .ena(c_ena), .cin(l_cout), .sclr(1'b0), .sload(c_sload),
      .load_data(h_ld), .up_dn(1'b1), .capture(1'b0), .snap_ack(1'b0),
      .regout(h_q), .cout(h_cout), .tc(h_tc), .done(h_done), .snap_data(h_snap), .snap_valid(h_sv));

   ad_nios_param_counter #(.WIDTH(16), .MODULUS(0), .POWER_UP(0), .MODE(0), .CIN_USED(0), .UPDOWN_USED(1)) u_d (
      .clk(clk), .aclr(aclr), .ena(d_ena), .cin(1'b0), .sclr(1'b0), .sload(d_sload),
      .load_data(d_ld), .up_dn(1'b1), .capture(d_cap), .snap_ack(d_ack),
      .regout(d_q), .cout(d_cout), .tc(d_tc), .done(d_done), .snap_data(d_snap), .snap_valid(d_sv));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int tc_seen;

   initial begin
      aclr = 1'b1;
      a_ena = 0; a_sclr = 0; a_sload = 0; a_updn = 1; a_cap = 0; a_ack = 0; a_ld = '0;
      b_ena = 0; b_sclr = 0; b_sload = 0; b_updn = 1; b_ld = '0;
      c_ena = 0; c_sload = 0; l_ld = '0; h_ld = '0;
      d_ena = 0; d_sload = 0; d_cap = 0; d_ack = 0; d_ld = '0;
      repeat (2) @(posedge clk);
      #1 aclr = 1'b0;

      // reset state
      chk("rst_a_q", a_q, 8'd5);
      chk("rst_a_tc", a_tc, 1'b0);
      chk("rst_a_sv", a_sv, 1'b0);
      chk("rst_b_done", b_done, 1'b0);
      chk("rst_b_cout", b_cout, 1'b0);

      // count a little with a capture, then async clear mid-cycle
      a_ena = 1; a_updn = 1; a_cap = 1;
      step();
      chk("pre_a_q6", a_q, 8'd6);
      chk("pre_a_sv", a_sv, 1'b1);
      chk("pre_a_snap", a_snap, 8'd5);
      a_cap = 0;
      step();
      chk("pre_a_q7", a_q, 8'd7);
      #2 aclr = 1'b1;
      #1;
      chk("aclr_a_q", a_q, 8'd5);
      chk("aclr_a_sv", a_sv, 1'b0);
      chk("aclr_a_tc", a_tc, 1'b0);
      a_ena = 0;
      #1 aclr = 1'b0;

      // wrap at modulus 10
      a_ena = 1; a_sclr = 1;
      step();
      chk("sclr_a_q", a_q, 8'd0);
      a_sclr = 0;
      tc_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         tc_seen += int'(a_tc);
         if (i == 9) chk("wrap_a_q9", a_q, 8'd9);
      end
      chk("wrap_a_q0", a_q, 8'd0);
      chk("wrap_a_tc", a_tc, 1'b1);
      chk("wrap_tc_once", tc_seen, 1);
      a_ena = 0;
      step();
      chk("idle_a_tc", a_tc, 1'b0);
      chk("idle_a_q", a_q, 8'd0);
      a_ena = 1; a_updn = 0;
      step();
      chk("down_a_q", a_q, 8'd9);
      chk("down_a_tc", a_tc, 1'b1);

      // priority and clamped load
      a_sclr = 1; a_sload = 1; a_ld = 8'd7;
      step();
      chk("prio_sclr", a_q, 8'd0);
      a_sclr = 0; a_ena = 0; a_ld = 8'd3;
      step();
      chk("prio_noena", a_q, 8'd0);
      a_ena = 1; a_ld = 8'd200;
      step();
      chk("load_clamp", a_q, 8'd9);
      chk("load_no_tc", a_tc, 1'b0);
      a_ld = 8'd4;
      step();
      chk("load_4", a_q, 8'd4);
      a_sload = 0; a_ena = 0;

      // one-shot
      b_ena = 1; b_updn = 1;
      step();
      chk("os_idle_hold", b_q, 4'd0);
      b_sload = 1; b_ld = 4'd13;
      step();
      chk("os_load13", b_q, 4'd13);
      b_sload = 0;
      step();
      chk("os_14", b_q, 4'd14);
      step();
      chk("os_15", b_q, 4'd15);
      chk("os_cout_run", b_cout, 1'b1);
      chk("os_done_run", b_done, 1'b0);
      step();
      chk("os_hold15", b_q, 4'd15);
      chk("os_done", b_done, 1'b1);
      chk("os_tc", b_tc, 1'b1);
      step();
      chk("os_hold15b", b_q, 4'd15);
      chk("os_tc_once", b_tc, 1'b0);
      chk("os_cout_halt", b_cout, 1'b0);
      b_sload = 1; b_ld = 4'd0;
      step();
      chk("os_rearm_done", b_done, 1'b0);
      chk("os_rearm_q", b_q, 4'd0);
      b_sload = 0; b_ena = 0;

      // cascade
      c_ena = 1; c_sload = 1; l_ld = 4'hE; h_ld = 4'h0;
      step();
      chk("casc_0e", {h_q, l_q}, 8'h0E);
      c_sload = 0;
      step();
      chk("casc_0f", {h_q, l_q}, 8'h0F);
      step();
      chk("casc_10", {h_q, l_q}, 8'h10);
      c_sload = 1; l_ld = 4'hF; h_ld = 4'hF;
      step();
      chk("casc_ff", {h_q, l_q}, 8'hFF);
      chk("casc_hcout", h_cout, 1'b1);
      c_sload = 0;
      step();
      chk("casc_00", {h_q, l_q}, 8'h00);
      c_ena = 0;

      // snapshot handshake
      d_ena = 1; d_sload = 1; d_ld = 16'h1234;
      step();
      chk("snap_ld", d_q, 16'h1234);
      chk("snap_sv0", d_sv, 1'b0);
      d_sload = 0; d_cap = 1;
      step();
      chk("snap_data1", d_snap, 16'h1234);
      chk("snap_sv1", d_sv, 1'b1);
      d_cap = 0; d_sload = 1; d_ld = 16'h1240;
      step();
      chk("snap_ld2", d_q, 16'h1240);
      d_sload = 0; d_cap = 1; d_ack = 1;
      step();
      chk("snap_capack_sv", d_sv, 1'b1);
      chk("snap_capack_data", d_snap, 16'h1240);
      d_cap = 0; d_ena = 0;
      step();
      chk("snap_ack_sv", d_sv, 1'b0);
      chk("snap_ack_data", d_snap, 16'h1240);
      d_ack = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
